pipeline_hazard_ctrl: RTL

//  Parametrised hazard/forwarding controller for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB).

---
 rtl/pipeline_hazard_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: hazard, stall, flush and forwarding controller for a 5-stage IF/ID/EX/MEM/WB pipeline.
// Latency: all control and forwarding outputs are combinational from the inputs and the current state. Perf counters update at the clock edge.
// Backpressure: a data-memory wait freezes ID/EX..MEM/WB and holds PC and IF/ID. A load-use or RAW stall holds PC and IF/ID and bubbles ID/EX.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   id_rs1/id_rs2/id_uses_rs2      sources of the instruction in ID
//   ex_rs1/ex_rs2/ex_rd            ID/EX register fields
//   ex_mem_read/ex_reg_write       ID/EX flags
//   mem_rd/mem_reg_write           EX/MEM destination
//   wb_rd/wb_reg_write             MEM/WB destination
//   mem_access/dmem_ready          EX/MEM data-memory handshake
//   branch_taken                   taken branch resolved in BRANCH_STAGE
//   pc_write/ifid_write            front-end enables
//   idex_bubble/freeze/flush       pipeline register controls
//   forward_a/forward_b            EX operand mux selects
//   stall_cycles/flush_events      saturating perf counters
module pipeline_hazard_ctrl #(
  parameter int REG_AW          = 5,
  parameter int BRANCH_STAGE    = 3,
  parameter int LOAD_USE_STALLS = 1,
  parameter int FWD_ENABLE      = 1,
  parameter int CNT_W           = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  input  logic              mem_access,
  input  logic              dmem_ready,
  input  logic              branch_taken,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_bubble,
  output logic              freeze,
  output logic [2:0]        flush,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_events
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  // An EX-resolved branch has nothing younger in EX/MEM to kill.
  localparam logic [2:0]       FLUSH_BR  = (BRANCH_STAGE == 2) ? 3'b011 : 3'b111;
  localparam logic [2:0]       LU_RELOAD = 3'(LOAD_USE_STALLS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t     state, state_nxt;
  logic [2:0] scnt, scnt_nxt;

  logic ex_hit, mem_hit, lu, raw, mem_stall;

  // x0 is never a hazard: every match requires a nonzero destination.
  always_comb begin
    ex_hit  = ex_reg_write & (ex_rd != '0) &
              ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));
    mem_hit = mem_reg_write & (mem_rd != '0) &
              ((mem_rd == id_rs1) | (id_uses_rs2 & (mem_rd == id_rs2)));
    lu        = ex_mem_read & ex_hit;
    // WB-stage producers are covered by the write-first register file.
    raw       = (FWD_ENABLE == 0) & (ex_hit | mem_hit);
    mem_stall = mem_access & ~dmem_ready;
  end

  always_comb begin
    state_nxt   = state;
    scnt_nxt    = scnt;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    freeze      = 1'b0;
    flush       = 3'b000;
    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      flush       = 3'b111;
      state_nxt   = RUN;
      scnt_nxt    = 3'd0;
    end else if (state == MEM_WAIT && !dmem_ready) begin
      freeze     = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (state == LU_STALL) begin
      if (mem_stall) begin
        // The memory wait outranks the remaining bubbles; ID is re-checked afterwards.
        freeze     = 1'b1;
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        state_nxt  = MEM_WAIT;
        scnt_nxt   = 3'd0;
      end else if (branch_taken) begin
        flush     = FLUSH_BR;
        state_nxt = RUN;
        scnt_nxt  = 3'd0;
      end else begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        if (scnt <= 3'd1) begin
          state_nxt = RUN;
          scnt_nxt  = 3'd0;
        end else begin
          scnt_nxt = scnt - 3'd1;
        end
      end
    end else begin
      // RUN, or the MEM_WAIT cycle in which the access completes. In that cycle the
      // pipeline advances again, so a branch held during the wait is acted on here.
      state_nxt = RUN;
      if (mem_stall) begin
        freeze     = 1'b1;
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        state_nxt  = MEM_WAIT;
      end else if (branch_taken) begin
        flush = FLUSH_BR;
      end else if (lu || raw) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        // The first bubble is this cycle; LU_STALL supplies the rest.
        if (lu && LOAD_USE_STALLS > 1) begin
          state_nxt = LU_STALL;
          scnt_nxt  = LU_RELOAD;
        end
      end
    end
  end

  // EX/MEM wins over MEM/WB because it holds the younger value.
  always_comb begin
    forward_a = 2'b00;
    forward_b = 2'b00;
    if (FWD_ENABLE != 0 && !reset) begin
      if (mem_reg_write && mem_rd != '0 && mem_rd == ex_rs1)
        forward_a = 2'b10;
      else if (wb_reg_write && wb_rd != '0 && wb_rd == ex_rs1)
        forward_a = 2'b01;
      if (mem_reg_write && mem_rd != '0 && mem_rd == ex_rs2)
        forward_b = 2'b10;
      else if (wb_reg_write && wb_rd != '0 && wb_rd == ex_rs2)
        forward_b = 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      scnt         <= 3'd0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      state <= state_nxt;
      scnt  <= scnt_nxt;
      if (!pc_write && stall_cycles != '1)
        stall_cycles <= stall_cycles + CNT_ONE;
      if (flush != 3'b000 && flush_events != '1)
        flush_events <= flush_events + CNT_ONE;
    end
  end

endmodule
